// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 4-bit ALU: queues host commands in a small FIFO, owns the
// accumulator and sticky flags, and repeats each ALU operation rep+1 times.
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_data,
  input  logic [1:0] cmd_rep,
  input  logic       cmd_load,
  output logic [3:0] alu_n1,
  output logic [3:0] alu_n2,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_x,
  input  logic [1:0] alu_ccr,
  output logic [3:0] acc,
  output logic       flag_c,
  output logic       flag_v,
  input  logic       clr_flags,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StExec, StFin} state_e;

  localparam int unsigned EntW = 10;
  localparam logic [PTR_W:0] Full = (PTR_W + 1)'(DEPTH);

  state_e            r_state, w_state_d;
  logic [EntW-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [PTR_W:0]    r_count;
  logic [2:0]        r_cur_op;
  logic [3:0]        r_cur_data;
  logic [1:0]        r_cnt;
  logic [3:0]        r_acc;
  logic              r_flag_c, r_flag_v;

  logic              w_full, w_empty, w_push, w_pop, w_exec;
  logic [EntW-1:0]   w_head;

  // Entry layout: {op[9:7], data[6:3], rep[2:1], load[0]}
  assign w_full  = (r_count == Full);
  assign w_empty = (r_count == '0);
  assign w_push  = cmd_valid && !w_full;
  assign w_pop   = (r_state == StIdle) && !w_empty;
  assign w_exec  = (r_state == StExec);
  assign w_head  = r_mem[r_rptr];

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (w_pop) w_state_d = w_head[0] ? StFin : StExec;
      StExec:  if (r_cnt == '0) w_state_d = StFin;
      StFin:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {cmd_op, cmd_data, cmd_rep, cmd_load};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_cur_op   <= '0;
      r_cur_data <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_flag_c   <= 1'b0;
      r_flag_v   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;

      if (w_pop) begin
        r_cur_op   <= w_head[9:7];
        r_cur_data <= w_head[6:3];
        r_cnt      <= w_head[2:1];
        if (w_head[0]) r_acc <= w_head[6:3];
      end

      if (w_exec) begin
        r_acc <= alu_x;
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        // A flag raised by this write survives a simultaneous clear.
        r_flag_c <= (r_flag_c & ~clr_flags) | alu_ccr[1];
        r_flag_v <= (r_flag_v & ~clr_flags) | alu_ccr[0];
      end else if (clr_flags) begin
        r_flag_c <= 1'b0;
        r_flag_v <= 1'b0;
      end
    end
  end

  assign cmd_ready = !w_full;
  assign alu_n1    = r_acc;
  assign alu_n2    = r_cur_data;
  assign alu_op    = w_exec ? r_cur_op : 3'b000;
  assign acc       = r_acc;
  assign flag_c    = r_flag_c;
  assign flag_v    = r_flag_v;
  assign busy      = (r_state != StIdle) || !w_empty;
  assign done      = (r_state == StFin);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer; a behavioural 4-bit ALU closes the alu_* loop.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst, cmd_valid, cmd_ready, cmd_load, clr_flags, flag_c, flag_v, busy, done;
  logic [2:0] cmd_op, alu_op;
  logic [3:0] cmd_data, alu_n1, alu_n2, alu_x, acc;
  logic [1:0] cmd_rep, alu_ccr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_rep(cmd_rep), .cmd_load(cmd_load), .alu_n1(alu_n1),
    .alu_n2(alu_n2), .alu_op(alu_op), .alu_x(alu_x), .alu_ccr(alu_ccr), .acc(acc),
    .flag_c(flag_c), .flag_v(flag_v), .clr_flags(clr_flags), .busy(busy), .done(done)
  );

  // ALU: 000 add, 001 sub, 010 shl, 011 shr, 100 not, 101 and, 110 or, 111 xor; ccr={c,v}
  always_comb begin
    logic [4:0] s;
    s       = 5'd0;
    alu_x   = 4'd0;
    alu_ccr = 2'b00;
    case (alu_op)
      3'b000: begin
        s = {1'b0, alu_n1} + {1'b0, alu_n2};
        alu_x = s[3:0];
        alu_ccr = {s[4], (alu_n1[3] == alu_n2[3]) && (s[3] != alu_n1[3])};
      end
      3'b001: begin
        s = {1'b0, alu_n1} - {1'b0, alu_n2};
        alu_x = s[3:0];
        alu_ccr = {s[4], (alu_n1[3] != alu_n2[3]) && (s[3] != alu_n1[3])};
      end
      3'b010:  alu_x = {alu_n1[2:0], 1'b0};
      3'b011:  alu_x = {1'b0, alu_n1[3:1]};
      3'b100:  alu_x = ~alu_n1;
      3'b101:  alu_x = alu_n1 & alu_n2;
      3'b110:  alu_x = alu_n1 | alu_n2;
      default: alu_x = alu_n1 ^ alu_n2;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] op, input logic [3:0] d, input logic [1:0] rep,
                       input logic ld);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_rep   = rep;
    cmd_load  = ld;
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] d, input logic [1:0] rep,
                      input logic ld);
    drive(op, d, rep, ld);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit timeout);
    timeout = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!busy) begin
        timeout = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (acc !== 4'd0) begin errors++; $display("FAIL rst_acc got %b want 0000", acc); end
    checks++; if ({flag_c, flag_v} !== 2'b00) begin
      errors++; $display("FAIL rst_flags got %b want 00", {flag_c, flag_v}); end
    checks++; if ({done, busy, cmd_ready} !== 3'b001) begin
      errors++; $display("FAIL rst_ctl got %b want 001 (done,busy,ready)", {done, busy, cmd_ready});
    end
    checks++; if ({alu_op, alu_n2} !== 7'd0) begin
      errors++; $display("FAIL rst_alu got %b want 0000000", {alu_op, alu_n2}); end
  endtask

  task automatic test_load_add;
    send(3'b000, 4'b0111, 2'd0, 1'b1);
    checks++; if ({done, busy} !== 2'b01) begin
      errors++; $display("FAIL nobypass got %b want 01 (done,busy)", {done, busy}); end
    tick();
    checks++; if ({acc, done} !== 5'b0111_1) begin
      errors++; $display("FAIL load_done got %b want 01111 (acc,done)", {acc, done}); end
    send(3'b000, 4'b0001, 2'd0, 1'b0);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL fin_one got %b want 0", done); end
    tick();
    checks++; if ({alu_n1, alu_n2, done} !== 9'b0111_0001_0) begin
      errors++; $display("FAIL exec_ops got %b want 011100010", {alu_n1, alu_n2, done}); end
    tick();
    checks++; if ({acc, flag_c, flag_v, done} !== 7'b1000_0_1_1) begin
      errors++; $display("FAIL add_ovf got %b want 1000011", {acc, flag_c, flag_v, done}); end
    tick();
    checks++; if ({done, busy} !== 2'b00) begin
      errors++; $display("FAIL add_end got %b want 00", {done, busy}); end
  endtask

  task automatic test_carry_clear;
    bit to1, to2;
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    send(3'b000, 4'b1111, 2'd0, 1'b1);
    wait_idle(to1);
    send(3'b000, 4'b0001, 2'd0, 1'b0);
    wait_idle(to2);
    checks++; if (to1 || to2) begin
      errors++; $display("FAIL carry_timeout got %b want 00", {to1, to2}); end
    checks++; if ({acc, flag_c, flag_v} !== 6'b0000_1_0) begin
      errors++; $display("FAIL carry got %b want 000010", {acc, flag_c, flag_v}); end
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    checks++; if ({flag_c, flag_v} !== 2'b00) begin
      errors++; $display("FAIL clr got %b want 00", {flag_c, flag_v}); end
  endtask

  task automatic test_shift_repeat;
    bit to;
    logic [3:0] exp_acc [3];
    exp_acc = '{4'b0110, 4'b1100, 4'b1000};
    send(3'b000, 4'b0011, 2'd0, 1'b1);
    wait_idle(to);
    send(3'b010, 4'b0000, 2'd2, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({acc, done} !== {exp_acc[i], (i == 2)}) begin
        errors++; $display("FAIL shl_step%0d got %b want %b", i, {acc, done}, {exp_acc[i], (i == 2)});
      end
    end
    checks++; if ({flag_c, flag_v} !== 2'b00) begin
      errors++; $display("FAIL shl_flags got %b want 00", {flag_c, flag_v}); end
    tick();
    checks++; if ({done, busy, to} !== 3'b000) begin
      errors++; $display("FAIL shl_end got %b want 000", {done, busy, to}); end
  endtask

  task automatic test_back_to_back;
    logic [2:0] ops [6];
    logic [3:0] dat [6];
    logic [1:0] rep [6];
    logic       ld  [6];
    logic [3:0] exp_acc [7];
    int idx, nd;
    bit acc_next, full_seen;
    ops = '{3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 3'b111};
    dat = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd4, 4'd15};
    rep = '{2'd0, 2'd1, 2'd0, 2'd3, 2'd0, 2'd0};
    ld  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_acc = '{4'd8, 4'd1, 4'd5, 4'd6, 4'd10, 4'd4, 4'd11};
    idx = 0;
    nd = 0;
    full_seen = 1'b0;
    send(3'b000, 4'd0, 2'd3, 1'b0);
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (idx < 6) begin
        drive(ops[idx], dat[idx], rep[idx], ld[idx]);
        acc_next = cmd_ready;
      end else begin
        cmd_valid = 1'b0;
        acc_next = 1'b0;
      end
      tick();
      if (acc_next) idx++;
      if (done) begin
        checks++;
        if (nd >= 7) begin
          errors++; $display("FAIL b2b_extra_done got %0d want 7", nd + 1);
        end else if (acc !== exp_acc[nd]) begin
          errors++; $display("FAIL b2b_acc%0d got %b want %b", nd, acc, exp_acc[nd]);
        end
        nd++;
      end
      if (idx == 4 && !full_seen) begin
        full_seen = 1'b1;
        checks++; if (cmd_ready !== 1'b0) begin
          errors++; $display("FAIL b2b_full got ready=%b want 0", cmd_ready); end
      end
      if (idx == 6 && !busy) break;
    end
    cmd_valid = 1'b0;
    checks++; if (nd != 7 || idx != 6 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_count got done=%0d pushed=%0d busy=%b want 7 6 0", nd, idx, busy);
    end
  endtask

  task automatic test_reset_mid;
    bit to;
    send(3'b000, 4'b0101, 2'd0, 1'b1);
    wait_idle(to);
    send(3'b111, 4'b0011, 2'd3, 1'b0);
    tick();
    tick();
    checks++; if ({acc, busy, to} !== 6'b0110_1_0) begin
      errors++; $display("FAIL xor_first got %b want 011010", {acc, busy, to}); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({acc, flag_c, flag_v, busy, cmd_ready, done} !== 9'b0000_0_0_0_1_0) begin
      errors++; $display("FAIL midrst got %b want 000000010", {acc, flag_c, flag_v, busy, cmd_ready, done});
    end
    tick();
    checks++; if ({acc, done, busy} !== 6'b0000_0_0) begin
      errors++; $display("FAIL midrst_after got %b want 000000", {acc, done, busy}); end
  endtask

  task automatic test_set_wins;
    bit to;
    send(3'b000, 4'b1000, 2'd0, 1'b1);
    wait_idle(to);
    send(3'b000, 4'b1000, 2'd0, 1'b0);
    tick();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    checks++; if ({acc, flag_c, flag_v, done, to} !== 8'b0000_1_1_1_0) begin
      errors++; $display("FAIL set_wins got %b want 00001110", {acc, flag_c, flag_v, done, to}); end
    wait_idle(to);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_data  = '0;
    cmd_rep   = '0;
    cmd_load  = 1'b0;
    clr_flags = 1'b0;
    test_reset();
    test_load_add();
    test_carry_clear();
    test_shift_repeat();
    test_back_to_back();
    test_reset_mid();
    test_set_wins();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
